adc_sample_decimator: RTL and testbench
=======================================

# adc_sample_decimator

Consumes the raw XADC conversion stream from the ADC front end (`adc_data_out` / `adc_data_valid`) and turns it into a decimated, signed, rounded sample stream for the modem demodulator. It extracts the 12-bit XADC code and converts it to two's complement, then averages 2^DECIM_LOG2 consecutive samples. Results are buffered in a small FIFO behind a valid/ready handshake, and dropped results are flagged.

## Interface
- `DECIM_LOG2`, 3: log2 of the decimation ratio; legal range 0..6 (0 = pass-through, no averaging).
- `FIFO_LOG2`, 2: log2 of the output FIFO depth (default 4 entries).
- `UNIPOLAR`, 1: 1 = input code is offset-binary and its MSB is inverted; 0 = code is already two's complement.

- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `adc_data_in`  in  16  raw XADC word; code in [15:4], [3:0] ignored.
- `adc_data_valid`  in  1  one-cycle strobe qualifying `adc_data_in`.
- `sample_out`  out  16  signed averaged sample, left-aligned: {avg[11:0], 4'b0}.
- `sample_valid`  out  1  FIFO non-empty.
- `sample_ready`  in  1  consumer accepts `sample_out` when high together with `sample_valid`.
- `overflow`  out  1  sticky; a result was dropped because the FIFO was full.
- `clear_overflow`  in  1  one-cycle clear of `overflow`.

## Operation
- Stage 1 (convert), on a cycle with `adc_data_valid`=1: code = `adc_data_in[15:4]`. If UNIPOLAR=1, code[11] is inverted. The result is registered as a 12-bit signed value with a stage-1 valid flag.
- Stage 2 (accumulate): when stage-1 valid is set, the 12-bit value is sign-extended to 12+DECIM_LOG2 bits and added to the accumulator; the sample counter increments.
  - When the counter reaches 2^DECIM_LOG2−1, the result is produced and the accumulator and counter are reset to 0 in the same cycle.
  - Result = (acc_final + 2^(DECIM_LOG2−1)) >>> DECIM_LOG2, arithmetic shift, round half up. No rounding term is added when DECIM_LOG2=0.
  - The result fits in 12 bits signed; no saturation is needed.
- FIFO:
  - A result is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the result is dropped and `overflow` is set. The accumulator restarts regardless of whether the result was pushed.
- Pop occurs on `sample_valid && sample_ready`.
  - `sample_out` always shows the head entry.
  - `sample_out` is 16'h0000 when the FIFO is empty.
- `overflow`: a set and `clear_overflow` in the same cycle resolve to set.
- Reset: the accumulator, counter, stage-1 flag and FIFO pointers are cleared, so any partial accumulation is discarded. `overflow` is cleared.
  - Reset values: `sample_out`=0, `sample_valid`=0, `overflow`=0.
  - Inputs are ignored while `reset`=0.

## Timing
- Edge t samples the final `adc_data_valid` of a group; stage-1 is registered at edge t.
- Edge t+1 accumulates and computes the result; edge t+2 writes the FIFO.
- `sample_valid` is high after edge t+2. Latency is 2 cycles, with any back-to-back input rate supported (valid every cycle).
- Pop takes effect at the edge where the handshake holds; the next head entry is visible in the following cycle.
- No combinational path exists from `sample_ready` to `sample_valid` or `sample_out`.
- With DECIM_LOG2=0, every input produces one result; at a 1-per-cycle input rate the throughput is 1 per cycle.

## Structure
- Package `adc_pkg`:
  - `XADC_CODE_W`=12, `XADC_CODE_LSB`=4.
  - Function `xadc_to_signed(code, unipolar)`, shared with other ADC-side blocks.
- Sub-module `adc_sample_fifo`:
  - Parameters: width 16, depth 2^FIFO_LOG2.
  - Ports: push/pop/full/empty/head.
  - Pointers are FIFO_LOG2+1 bits, so full and empty are distinguished by the wrap bit.
- Conversion and accumulation stay in the top module.

## Test plan
- Reset: hold `reset`=0 for 3 cycles while driving valid inputs → `sample_valid`=0, `sample_out`=0, `overflow`=0 throughout and after release.
- DECIM_LOG2=2, UNIPOLAR=1: four valids with `adc_data_in`=16'hA000 (code 0xA00 → signed 0x200) → exactly one result, `sample_out`=16'h2000, `sample_valid` rising 2 cycles after the 4th valid. Three valids alone → no output.
- Rounding, DECIM_LOG2=2, UNIPOLAR=0: signed codes 1, 1, 0, 0 (sum 2) → avg 1 (16'h0010). Codes −1, −1, 0, 0 (sum −2) → avg 0 (16'h0000). Codes −3, 0, 0, 0 → avg −1 (16'hFFF0).
- Backpressure, DECIM_LOG2=0: `sample_ready`=0 with 6 valids → 4 entries held, `overflow`=1. `clear_overflow` pulse → 0. Set and clear in the same cycle → stays 1. Drain → first 4 inputs, in order.
- Full with simultaneous pop, DECIM_LOG2=0: with the FIFO full, a new result arrives on the same edge as a pop → push accepted, `overflow` stays 0, FIFO remains at 4 entries.
- Reset mid-group, DECIM_LOG2=3:
  - Drive 5 valids, pulse `reset`=0 for 1 cycle, then drive 8 valids of 16'h8000 with UNIPOLAR=1 → a single result 16'h0000.
  - No contribution from the pre-reset samples appears in that result.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: XADC code geometry and code-to-signed conversion shared by ADC-side blocks
package adc_pkg;
    localparam int XADC_CODE_W = 12;
    localparam int XADC_CODE_LSB = 4;
    function automatic logic signed [XADC_CODE_W-1:0] xadc_to_signed(
        input logic [XADC_CODE_W-1:0] code,
        input logic unipolar
    );
        return {code[XADC_CODE_W-1] ^ unipolar, code[XADC_CODE_W-2:0]};
    endfunction
endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: synchronous FIFO; pointers carry a wrap bit to tell full from empty, head reads 0 when empty
module adc_sample_fifo #(
    parameter int W = 16,
    parameter int LOG2 = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2**LOG2];
    logic [LOG2:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp ^ rp) == {1'b1, {LOG2{1'b0}}};
    assign head = empty ? '0 : mem[rp[LOG2-1:0]];
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wp[LOG2-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/adc_sample_decimator.sv
// adc_sample_decimator: converts XADC codes to signed, averages 2^DECIM_LOG2 samples with round-half-up, buffers results
module adc_sample_decimator
    import adc_pkg::*;
#(
    parameter int DECIM_LOG2 = 3,
    parameter int FIFO_LOG2 = 2,
    parameter bit UNIPOLAR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adc_data_in,
    input  logic        adc_data_valid,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overflow,
    input  logic        clear_overflow
);
    localparam int AW = XADC_CODE_W + DECIM_LOG2;
    localparam int CW = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << DECIM_LOG2) - 1);
    localparam logic signed [AW-1:0] RND = AW'((1 << DECIM_LOG2) >> 1);
    logic s1_val, res_val, full, empty, pop, drop;
    logic signed [XADC_CODE_W-1:0] s1_data, res;
    logic [CW-1:0] cnt;
    logic signed [AW-1:0] acc, acc_sum, rnd, shf;
    logic [15:0] head;
    always_comb begin
        acc_sum = acc + AW'(s1_data);
        rnd = acc_sum + RND;
        shf = rnd >>> DECIM_LOG2;
    end
    assign pop = !empty && sample_ready;
    assign drop = res_val && full && !pop;
    assign sample_valid = !empty;
    assign sample_out = head;
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_val <= 1'b0;
            res_val <= 1'b0;
            cnt <= '0;
            acc <= '0;
            overflow <= 1'b0;
        end else begin
            s1_val <= adc_data_valid;
            if (adc_data_valid) s1_data <= xadc_to_signed(adc_data_in[XADC_CODE_LSB +: XADC_CODE_W], UNIPOLAR);
            res_val <= s1_val && cnt == LAST;
            if (s1_val) begin
                res <= shf[XADC_CODE_W-1:0];
                cnt <= cnt == LAST ? '0 : cnt + 1'b1;
                acc <= cnt == LAST ? '0 : acc_sum;
            end
            overflow <= drop | (overflow & ~clear_overflow);
        end
    end
    adc_sample_fifo #(.W(16), .LOG2(FIFO_LOG2)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (res_val),
        .din   ({res, 4'b0}),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
endmodule

// File: tb/tb_adc_sample_decimator.sv
// tb_adc_sample_decimator: directed checks across four parameterisations sharing clock, reset and data bus
module tb_adc_sample_decimator;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] din = '0;
    logic [3:0] v = '0, rdy = '0, clr = '0;
    logic [15:0] so [4];
    logic [3:0] sv, ov;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    adc_sample_decimator #(.DECIM_LOG2(2), .FIFO_LOG2(2), .UNIPOLAR(1)) u_a (
        .clk(clk), .reset(reset), .adc_data_in(din), .adc_data_valid(v[0]), .sample_out(so[0]),
        .sample_valid(sv[0]), .sample_ready(rdy[0]), .overflow(ov[0]), .clear_overflow(clr[0]));
    adc_sample_decimator #(.DECIM_LOG2(2), .FIFO_LOG2(2), .UNIPOLAR(0)) u_b (
        .clk(clk), .reset(reset), .adc_data_in(din), .adc_data_valid(v[1]), .sample_out(so[1]),
        .sample_valid(sv[1]), .sample_ready(rdy[1]), .overflow(ov[1]), .clear_overflow(clr[1]));
    adc_sample_decimator #(.DECIM_LOG2(0), .FIFO_LOG2(2), .UNIPOLAR(1)) u_c (
        .clk(clk), .reset(reset), .adc_data_in(din), .adc_data_valid(v[2]), .sample_out(so[2]),
        .sample_valid(sv[2]), .sample_ready(rdy[2]), .overflow(ov[2]), .clear_overflow(clr[2]));
    adc_sample_decimator #(.DECIM_LOG2(3), .FIFO_LOG2(2), .UNIPOLAR(1)) u_d (
        .clk(clk), .reset(reset), .adc_data_in(din), .adc_data_valid(v[3]), .sample_out(so[3]),
        .sample_valid(sv[3]), .sample_ready(rdy[3]), .overflow(ov[3]), .clear_overflow(clr[3]));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic send(input int i, input logic [15:0] d);
        din = d;
        v[i] = 1'b1;
        tick();
        v[i] = 1'b0;
    endtask
    task automatic pop1(input int i);
        rdy[i] = 1'b1;
        tick();
        rdy[i] = 1'b0;
    endtask
    task automatic expect_out(input int i, input string tag, input logic [15:0] e);
        check({tag, " valid"}, 16'(sv[i]), 16'd1);
        check(tag, so[i], e);
    endtask
    logic [15:0] rv [3][4];
    logic [15:0] re [3];
    initial begin
        rv[0] = '{16'h0010, 16'h0010, 16'h0000, 16'h0000};
        rv[1] = '{16'hFFF0, 16'hFFF0, 16'h0000, 16'h0000};
        rv[2] = '{16'hFFD0, 16'h0000, 16'h0000, 16'h0000};
        re = '{16'h0010, 16'h0000, 16'hFFF0};
        din = 16'hA000;
        v = 4'hF;
        repeat (3) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                check("rst valid", 16'(sv[i]), 16'd0);
                check("rst out", so[i], 16'h0000);
                check("rst ovf", 16'(ov[i]), 16'd0);
            end
        end
        v = '0;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("post-rst valid", 16'(sv[i]), 16'd0);
            check("post-rst out", so[i], 16'h0000);
            check("post-rst ovf", 16'(ov[i]), 16'd0);
        end
        // unipolar average of four 0xA00 codes
        for (int j = 0; j < 4; j++) send(0, 16'hA000);
        tick();
        check("a latency t+1", 16'(sv[0]), 16'd0);
        tick();
        expect_out(0, "a avg", 16'h2000);
        pop1(0);
        check("a single result", 16'(sv[0]), 16'd0);
        for (int j = 0; j < 3; j++) send(0, 16'hA000);
        repeat (4) tick();
        check("a partial group", 16'(sv[0]), 16'd0);
        // round half up on signed codes
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) send(1, rv[k][j]);
            repeat (2) tick();
            expect_out(1, $sformatf("round%0d", k), re[k]);
            pop1(1);
            check("round popped", 16'(sv[1]), 16'd0);
        end
        // backpressure: six results into four entries
        for (int i = 1; i <= 6; i++) send(2, 16'h8000 | 16'(i << 4));
        repeat (2) tick();
        check("bp ovf set", 16'(ov[2]), 16'd1);
        expect_out(2, "bp head", 16'h0010);
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        check("bp ovf cleared", 16'(ov[2]), 16'd0);
        send(2, 16'h8070);
        tick();
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        check("bp set+clear", 16'(ov[2]), 16'd1);
        for (int i = 1; i <= 4; i++) begin
            expect_out(2, $sformatf("drain%0d", i), 16'(i << 4));
            pop1(2);
        end
        check("bp drained", 16'(sv[2]), 16'd0);
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        check("bp ovf cleared2", 16'(ov[2]), 16'd0);
        // full FIFO, push coincides with pop
        for (int i = 7; i <= 10; i++) send(2, 16'h8000 | 16'(i << 4));
        repeat (2) tick();
        expect_out(2, "full head", 16'h0070);
        send(2, 16'h80B0);
        tick();
        rdy[2] = 1'b1;
        tick();
        rdy[2] = 1'b0;
        check("full+pop ovf", 16'(ov[2]), 16'd0);
        for (int i = 8; i <= 11; i++) begin
            expect_out(2, $sformatf("full drain%0d", i), 16'(i << 4));
            pop1(2);
        end
        check("full drained", 16'(sv[2]), 16'd0);
        // reset in the middle of a group discards the partial sum
        for (int j = 0; j < 5; j++) send(3, 16'hFFF0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int j = 0; j < 8; j++) send(3, 16'h8000);
        tick();
        check("d no early result", 16'(sv[3]), 16'd0);
        tick();
        expect_out(3, "d mid-reset", 16'h0000);
        pop1(3);
        check("d single result", 16'(sv[3]), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
